// File: rtl/i2c_target_pkg.sv
// Shared types and bus constants for the I2C target endpoint.
package i2c_target_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddress,
    StAddressAck,
    StRxData,
    StRxAck,
    StTxData,
    StTxAck,
    StIgnore
  } targetState_t;

  localparam logic       ReadBit  = 1'b1;
  localparam logic       WriteBit = 1'b0;
  localparam logic       AckBit   = 1'b0;
  localparam logic       NackBit  = 1'b1;
  localparam logic [7:0] IdleByte = 8'hFF;

endpackage

// File: rtl/i2c_line_monitor.sv
// Oversamples SDA/SCL into the system clock domain and flags bus events.
module i2c_line_monitor #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic sdaIn,
  input  logic sclIn,
  output logic sclRise,
  output logic sclFall,
  output logic startDetected,
  output logic stopDetected,
  output logic sdaSampled
);

  logic [SyncStages-1:0] sdaSync;
  logic [SyncStages-1:0] sclSync;
  logic                  sdaPrev;
  logic                  sclPrev;
  logic                  sdaNow;
  logic                  sclNow;

  // Synchronizer chains plus one history flop; reset high because the idle bus is high,
  // which keeps reset release from looking like an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sdaSync <= '1;
      sclSync <= '1;
      sdaPrev <= 1'b1;
      sclPrev <= 1'b1;
    end else begin
      sdaSync <= {sdaSync[SyncStages-2:0], sdaIn};
      sclSync <= {sclSync[SyncStages-2:0], sclIn};
      sdaPrev <= sdaSync[SyncStages-1];
      sclPrev <= sclSync[SyncStages-1];
    end
  end

  assign sdaNow = sdaSync[SyncStages-1];
  assign sclNow = sclSync[SyncStages-1];

  assign sdaSampled    = sdaNow;
  assign sclRise       = sclNow & ~sclPrev;
  assign sclFall       = ~sclNow & sclPrev;
  assign startDetected = sclNow & sclPrev & sdaPrev & ~sdaNow;
  assign stopDetected  = sclNow & sclPrev & ~sdaPrev & sdaNow;

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: fixed 7-bit address, buffered write phase, array-served read phase.
// Optional clock stretching after each stored byte: define I2C_TARGET_CLOCK_STRETCH_EN.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  Address            = 7'h50,
  parameter int unsigned MaxBytesToReceive  = 16,
  parameter int unsigned MaxBytesToTransmit = 16,
  parameter int unsigned SyncStages         = 2
) (
  input  logic                                          clock,
  input  logic                                          reset,
  inout  wire                                           sda,
  inout  wire                                           scl,
  input  logic [MaxBytesToTransmit-1:0][7:0]            bytesToTransmit,
  input  logic [$clog2(MaxBytesToTransmit):0]           nrOfBytesToTransmit,
  output logic [MaxBytesToReceive-1:0][7:0]             bytesReceived,
  output logic [$clog2(MaxBytesToReceive):0]            nrOfBytesReceived,
  output logic                                          receiveDone,
  output logic                                          transmitDone,
  output logic                                          busy,
  output logic                                          overflow,
  input  logic                                          byteAccept
);

  localparam int unsigned RxIdxW = $clog2(MaxBytesToReceive);
  localparam int unsigned TxIdxW = $clog2(MaxBytesToTransmit);
  localparam int unsigned RxW    = RxIdxW + 1;
  localparam int unsigned TxW    = TxIdxW + 1;

  logic          sclRise;
  logic          sclFall;
  logic          startDetected;
  logic          stopDetected;
  logic          sdaSampled;

  targetState_t  state;
  logic [3:0]    bitCount;
  logic [7:0]    shiftReg;
  logic [7:0]    shifted;
  logic [7:0]    txByte;
  logic [7:0]    nextTxByte;
  logic [2:0]    txBitSel;
  logic          ackPhase;
  logic          readPhase;
  logic [RxW-1:0] rxIndex;
  logic [TxW-1:0] txIndex;
  logic          sdaLow;

  i2c_line_monitor #(
    .SyncStages(SyncStages)
  ) lineMonitor (
    .clock        (clock),
    .reset        (reset),
    .sdaIn        (sda),
    .sclIn        (scl),
    .sclRise      (sclRise),
    .sclFall      (sclFall),
    .startDetected(startDetected),
    .stopDetected (stopDetected),
    .sdaSampled   (sdaSampled)
  );

  assign sda      = sdaLow ? 1'b0 : 1'bz;
  assign shifted  = {shiftReg[6:0], sdaSampled};
  assign txBitSel = 3'd7 - bitCount[2:0];

`ifdef I2C_TARGET_CLOCK_STRETCH_EN
  logic sclLow;
  logic storedByte;
  assign scl = sclLow ? 1'b0 : 1'bz;
`else
  logic unusedByteAccept;
  assign unusedByteAccept = byteAccept;
  assign scl = 1'bz;
`endif

  // Byte to serve next; past the valid count (or the array) the bus sees IdleByte.
  always_comb begin
    nextTxByte = IdleByte;
    if (txIndex < nrOfBytesToTransmit && txIndex < TxW'(MaxBytesToTransmit)) begin
      nextTxByte = bytesToTransmit[txIndex[TxIdxW-1:0]];
    end
  end

  // Protocol FSM; START/STOP override every state and close an addressed phase.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= StIdle;
      bitCount          <= '0;
      shiftReg          <= '0;
      txByte            <= '0;
      ackPhase          <= 1'b0;
      readPhase         <= 1'b0;
      rxIndex           <= '0;
      txIndex           <= '0;
      sdaLow            <= 1'b0;
      bytesReceived     <= '0;
      nrOfBytesReceived <= '0;
      receiveDone       <= 1'b0;
      transmitDone      <= 1'b0;
      busy              <= 1'b0;
      overflow          <= 1'b0;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
      sclLow            <= 1'b0;
      storedByte        <= 1'b0;
`endif
    end else begin
      receiveDone  <= 1'b0;
      transmitDone <= 1'b0;
      if (startDetected || stopDetected) begin
        if (busy) begin
          if (readPhase) begin
            transmitDone <= 1'b1;
          end else begin
            receiveDone       <= 1'b1;
            nrOfBytesReceived <= rxIndex;
          end
        end
        busy     <= 1'b0;
        sdaLow   <= 1'b0;
        bitCount <= '0;
        ackPhase <= 1'b0;
        state    <= startDetected ? StAddress : StIdle;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
        sclLow   <= 1'b0;
`endif
      end else begin
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
        if (sclLow && byteAccept) begin
          sclLow <= 1'b0;
        end
`endif
        case (state)
          StAddress: begin
            if (sclRise) begin
              shiftReg <= shifted;
              bitCount <= bitCount + 4'd1;
              if (bitCount == 4'd7) begin
                bitCount <= '0;
                ackPhase <= 1'b0;
                if (shifted[7:1] == Address) begin
                  state     <= StAddressAck;
                  busy      <= 1'b1;
                  readPhase <= (shifted[0] == ReadBit);
                  if (shifted[0] == ReadBit) begin
                    txIndex <= '0;
                  end else begin
                    rxIndex  <= '0;
                    overflow <= 1'b0;
                  end
                end else begin
                  state <= StIgnore;
                end
              end
            end
          end
          StAddressAck: begin
            if (sclFall) begin
              if (!ackPhase) begin
                sdaLow   <= (AckBit == 1'b0);
                ackPhase <= 1'b1;
              end else begin
                ackPhase <= 1'b0;
                bitCount <= '0;
                if (readPhase) begin
                  txByte <= nextTxByte;
                  sdaLow <= ~nextTxByte[7];
                  state  <= StTxData;
                end else begin
                  sdaLow <= 1'b0;
                  state  <= StRxData;
                end
              end
            end
          end
          StRxData: begin
            if (sclRise) begin
              shiftReg <= shifted;
              bitCount <= bitCount + 4'd1;
              if (bitCount == 4'd7) begin
                bitCount <= '0;
                ackPhase <= 1'b0;
                state    <= StRxAck;
              end
            end
          end
          StRxAck: begin
            if (sclFall) begin
              if (!ackPhase) begin
                ackPhase <= 1'b1;
                if (rxIndex < RxW'(MaxBytesToReceive)) begin
                  bytesReceived[rxIndex[RxIdxW-1:0]] <= shiftReg;
                  rxIndex <= rxIndex + RxW'(1);
                  sdaLow  <= 1'b1;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
                  storedByte <= 1'b1;
`endif
                end else begin
                  overflow <= 1'b1;
                  sdaLow   <= 1'b0;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
                  storedByte <= 1'b0;
`endif
                end
              end else begin
                ackPhase <= 1'b0;
                sdaLow   <= 1'b0;
                state    <= StRxData;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
                sclLow   <= storedByte;
`endif
              end
            end
          end
          StTxData: begin
            if (sclRise) begin
              bitCount <= bitCount + 4'd1;
            end else if (sclFall) begin
              if (bitCount == 4'd8) begin
                sdaLow <= 1'b0;
                state  <= StTxAck;
              end else begin
                sdaLow <= ~txByte[txBitSel];
              end
            end
          end
          StTxAck: begin
            if (sclRise) begin
              if (sdaSampled == AckBit) begin
                ackPhase <= 1'b1;
                if (txIndex != TxW'(MaxBytesToTransmit)) begin
                  txIndex <= txIndex + TxW'(1);
                end
              end else begin
                state <= StIgnore;
              end
            end else if (sclFall && ackPhase) begin
              ackPhase <= 1'b0;
              bitCount <= '0;
              txByte   <= nextTxByte;
              sdaLow   <= ~nextTxByte[7];
              state    <= StTxData;
            end
          end
          default: begin
            sdaLow <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged master, scoreboard queues for ACKs and read bytes.
module tb_i2c_target;

  localparam int unsigned MaxRx  = 16;
  localparam int unsigned MaxTx  = 16;
  localparam int unsigned Budget = 1000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  wire  sda;
  wire  scl;
  logic mSdaLow = 1'b0;
  logic mSclLow = 1'b0;
  logic [MaxTx-1:0][7:0] bytesToTransmit = '0;
  logic [4:0]            nrOfBytesToTransmit = '0;
  logic [MaxRx-1:0][7:0] bytesReceived;
  logic [4:0]            nrOfBytesReceived;
  logic receiveDone, transmitDone, busy, overflow;
  logic byteAccept = 1'b0;

  int checks = 0;
  int failures = 0;
  int rxDoneCount = 0;
  int txDoneCount = 0;
  int holdCycles = 0;
  int curHold = 0;
  int maxHold = 0;
  int targetSdaLow = 0;
  logic watchSda = 1'b0;

  logic       ackQ[$];
  logic [7:0] byteQ[$];

  assign sda = mSdaLow ? 1'b0 : 1'bz;
  assign scl = mSclLow ? 1'b0 : 1'bz;
  pullup (sda);
  pullup (scl);

  i2c_target #(
    .Address           (7'h50),
    .MaxBytesToReceive (MaxRx),
    .MaxBytesToTransmit(MaxTx),
    .SyncStages        (2)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .sda                (sda),
    .scl                (scl),
    .bytesToTransmit    (bytesToTransmit),
    .nrOfBytesToTransmit(nrOfBytesToTransmit),
    .bytesReceived      (bytesReceived),
    .nrOfBytesReceived  (nrOfBytesReceived),
    .receiveDone        (receiveDone),
    .transmitDone       (transmitDone),
    .busy               (busy),
    .overflow           (overflow),
    .byteAccept         (byteAccept)
  );

  always #5 clock = ~clock;

  // Bus monitor: pulse counts, target-held SCL, target-driven SDA, byteAccept 40 clocks into a hold.
  initial begin
    forever begin
      @(negedge clock);
      if (receiveDone === 1'b1) rxDoneCount++;
      if (transmitDone === 1'b1) txDoneCount++;
      if (watchSda && sda === 1'b0 && !mSdaLow) targetSdaLow++;
      if (scl === 1'b0 && !mSclLow) begin
        holdCycles++;
        curHold++;
      end else begin
        if (curHold > maxHold) maxHold = curHold;
        curHold = 0;
      end
      byteAccept = (curHold == 40);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic waitClocks(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic waitSclHigh();
    int n;
    n = 0;
    while (scl !== 1'b1 && n < Budget) begin
      @(posedge clock);
      n++;
    end
    if (n >= Budget) begin
      checks++;
      failures++;
      $error("FAIL sclRelease observed=%b expected=1 after %0d clocks", scl, n);
    end
  endtask

  task automatic writeBit(input logic b);
    waitClocks(10);
    mSdaLow = ~b;
    waitClocks(10);
    mSclLow = 1'b0;
    waitSclHigh();
    waitClocks(20);
    mSclLow = 1'b1;
  endtask

  task automatic readBit(output logic b);
    mSdaLow = 1'b0;
    waitClocks(20);
    mSclLow = 1'b0;
    waitSclHigh();
    waitClocks(10);
    @(negedge clock);
    b = sda;
    waitClocks(10);
    mSclLow = 1'b1;
  endtask

  task automatic startCond();
    mSdaLow = 1'b1;
    waitClocks(20);
    mSclLow = 1'b1;
  endtask

  task automatic repStart();
    waitClocks(10);
    mSdaLow = 1'b0;
    waitClocks(10);
    mSclLow = 1'b0;
    waitSclHigh();
    waitClocks(20);
    mSdaLow = 1'b1;
    waitClocks(20);
    mSclLow = 1'b1;
  endtask

  task automatic stopCond();
    waitClocks(10);
    mSdaLow = 1'b1;
    waitClocks(10);
    mSclLow = 1'b0;
    waitSclHigh();
    waitClocks(20);
    mSdaLow = 1'b0;
    waitClocks(20);
  endtask

  task automatic writeByte(input logic [7:0] data, input logic expAck);
    logic [7:0] d;
    logic ack;
    d = data;
    ackQ.push_back(expAck);
    for (int i = 0; i < 8; i++) begin
      writeBit(d[7]);
      d = {d[6:0], 1'b0};
    end
    readBit(ack);
    check("ackBit", 32'(ack), 32'(ackQ.pop_front()));
  endtask

  task automatic readByte(input logic [7:0] expByte, input logic masterAck);
    logic [7:0] got;
    logic b;
    got = '0;
    byteQ.push_back(expByte);
    for (int i = 0; i < 8; i++) begin
      readBit(b);
      got = {got[6:0], b};
    end
    writeBit(masterAck);
    check("readByte", 32'(got), 32'(byteQ.pop_front()));
  endtask

  initial begin
    bytesToTransmit[0] = 8'hA5;
    bytesToTransmit[1] = 8'h3C;
    bytesToTransmit[2] = 8'h77;
    nrOfBytesToTransmit = 5'd2;

    // Reset state
    waitClocks(5);
    @(negedge clock);
    check("rstSda", 32'(sda), 32'(1'b1));
    check("rstScl", 32'(scl), 32'(1'b1));
    reset = 1'b0;
    waitClocks(5);
    @(negedge clock);
    check("rstBusy", 32'(busy), 32'(1'b0));
    check("rstOverflow", 32'(overflow), 32'(1'b0));
    check("rstNr", 32'(nrOfBytesReceived), 32'(0));
    check("rstBytes", 32'(bytesReceived == '0), 32'(1'b1));

    // Write 12,34,56 to 0x50
    startCond();
    writeByte(8'hA0, 1'b0);
    @(negedge clock);
    check("busyAddressed", 32'(busy), 32'(1'b1));
    writeByte(8'h12, 1'b0);
    writeByte(8'h34, 1'b0);
    writeByte(8'h56, 1'b0);
    stopCond();
    @(negedge clock);
    check("wrByte0", 32'(bytesReceived[0]), 32'(8'h12));
    check("wrByte1", 32'(bytesReceived[1]), 32'(8'h34));
    check("wrByte2", 32'(bytesReceived[2]), 32'(8'h56));
    check("wrNr", 32'(nrOfBytesReceived), 32'(3));
    check("wrDonePulses", 32'(rxDoneCount), 32'(1));
    check("wrBusyAfterStop", 32'(busy), 32'(1'b0));

    // Wrong address 0x51: NACK, target silent
    watchSda = 1'b1;
    startCond();
    writeByte(8'hA2, 1'b1);
    writeByte(8'h99, 1'b1);
    writeByte(8'h98, 1'b1);
    stopCond();
    watchSda = 1'b0;
    @(negedge clock);
    check("wrongAddrSda", 32'(targetSdaLow), 32'(0));
    check("wrongAddrRxDone", 32'(rxDoneCount), 32'(1));
    check("wrongAddrTxDone", 32'(txDoneCount), 32'(0));
    check("wrongAddrNr", 32'(nrOfBytesReceived), 32'(3));
    check("wrongAddrByte0", 32'(bytesReceived[0]), 32'(8'h12));

    // Read 3 bytes from 0x50 with 2 valid: A5, 3C, then idle FF
    startCond();
    writeByte(8'hA1, 1'b0);
    readByte(8'hA5, 1'b0);
    readByte(8'h3C, 1'b0);
    readByte(8'hFF, 1'b1);
    stopCond();
    @(negedge clock);
    check("rdTxDone", 32'(txDoneCount), 32'(1));
    check("rdRxDone", 32'(rxDoneCount), 32'(1));
    check("rdBusy", 32'(busy), 32'(1'b0));

    // Write 0x01, repeated START, read 2
    startCond();
    writeByte(8'hA0, 1'b0);
    writeByte(8'h01, 1'b0);
    repStart();
    @(negedge clock);
    check("srRxDone", 32'(rxDoneCount), 32'(2));
    check("srNr", 32'(nrOfBytesReceived), 32'(1));
    check("srByte0", 32'(bytesReceived[0]), 32'(8'h01));
    check("srBusyDropped", 32'(busy), 32'(1'b0));
    writeByte(8'hA1, 1'b0);
    readByte(8'hA5, 1'b0);
    readByte(8'h3C, 1'b1);
    stopCond();
    @(negedge clock);
    check("srTxDone", 32'(txDoneCount), 32'(2));

    // Overflow: 18 bytes into a 16-byte buffer
    startCond();
    writeByte(8'hA0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      writeByte(8'h40 + 8'(i), (i >= 16));
    end
    @(negedge clock);
    check("ovfSticky", 32'(overflow), 32'(1'b1));
    stopCond();
    @(negedge clock);
    check("ovfNr", 32'(nrOfBytesReceived), 32'(16));
    check("ovfFirst", 32'(bytesReceived[0]), 32'(8'h40));
    check("ovfLast", 32'(bytesReceived[15]), 32'(8'h4F));
    check("ovfRxDone", 32'(rxDoneCount), 32'(3));

    // Reset mid byte 5 of a repeat write
    startCond();
    writeByte(8'hA0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      writeByte(8'h20 + 8'(i), 1'b0);
    end
    writeBit(1'b1);
    writeBit(1'b1);
    writeBit(1'b1);
    waitClocks(3);
    #3;
    reset = 1'b1;
    mSclLow = 1'b0;
    mSdaLow = 1'b0;
    #1;
    check("midRstSda", 32'(sda), 32'(1'b1));
    check("midRstScl", 32'(scl), 32'(1'b1));
    check("midRstBusy", 32'(busy), 32'(1'b0));
    check("midRstNr", 32'(nrOfBytesReceived), 32'(0));
    check("midRstBytes", 32'(bytesReceived == '0), 32'(1'b1));
    check("midRstRxDone", 32'(receiveDone), 32'(1'b0));
    waitClocks(10);
    reset = 1'b0;
    waitClocks(10);

`ifdef I2C_TARGET_CLOCK_STRETCH_EN
    check("stretchHold40", 32'(maxHold >= 40), 32'(1'b1));
`else
    check("noStretch", 32'(holdCycles), 32'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
